regfile_mp: RTL and testbench

Parametrised multi-read-port register file with byte-strobed writes, optional write-to-read bypass, optional hardwired zero register and a per-register busy scoreboard. It is the next-generation architectural register file for the pipeline. Decode allocates pending destinations here. Writeback commits results and clears pending state. Operand fetch reads data and busy status in the same cycle.

---
 rtl/regfile_mp_if.sv | 44 ++++
 rtl/regfile_mp.sv | 129 ++++++++++++
 tb/tb_regfile_mp.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp_if
//  Description : Bus bundle for the regfile_mp multi-port register file.
//                master = pipeline side (drives addresses, writes, allocs),
//                slave  = register file (returns data, busy, ack, count).
//  Signals     : rf_raddr/rf_rdata/rf_rbusy  - NUM_RD packed read ports
//                rf_we/rf_waddr/rf_wdata/rf_wstrb - byte-strobed write
//                alloc_valid/alloc_addr/flush - busy scoreboard control
//                wr_ack/wr_count              - write acknowledge / counter
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 16
);
  logic [NUM_RD*ADDR_W-1:0] rf_raddr;
  logic [NUM_RD*DATA_W-1:0] rf_rdata;
  logic [NUM_RD-1:0]        rf_rbusy;
  logic                     rf_we;
  logic [ADDR_W-1:0]        rf_waddr;
  logic [DATA_W-1:0]        rf_wdata;
  logic [DATA_W/8-1:0]      rf_wstrb;
  logic                     alloc_valid;
  logic [ADDR_W-1:0]        alloc_addr;
  logic                     flush;
  logic                     wr_ack;
  logic [CNT_W-1:0]         wr_count;

  modport master (
    output rf_raddr, rf_we, rf_waddr, rf_wdata, rf_wstrb,
           alloc_valid, alloc_addr, flush,
    input  rf_rdata, rf_rbusy, wr_ack, wr_count
  );

  modport slave (
    input  rf_raddr, rf_we, rf_waddr, rf_wdata, rf_wstrb,
           alloc_valid, alloc_addr, flush,
    output rf_rdata, rf_rbusy, wr_ack, wr_count
  );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Architectural register file with NUM_RD combinational read
//                ports, byte-strobed writes, optional write-to-read bypass,
//                optional hardwired zero register and a per-register busy
//                scoreboard (set by decode alloc, cleared by writeback).
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous, active-high; clears storage, busy,
//                        wr_ack and wr_count
//                rf    - regfile_mp_if.slave bundle (read ports, write port,
//                        alloc/flush, wr_ack, wr_count)
//  Note        : DATA_W/ADDR_W/NUM_RD/CNT_W must match the bound interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  regfile_mp_if.slave rf
);

  localparam int c_DEPTH  = 2**ADDR_W;
  localparam int c_NBYTES = DATA_W/8;

  logic [DATA_W-1:0]  r_mem [c_DEPTH];
  logic [c_DEPTH-1:0] r_busy;
  logic [c_DEPTH-1:0] w_busy_nxt;
  logic               r_wr_ack;
  logic [CNT_W-1:0]   r_wr_count;

  logic               w_wr_accept;
  logic [DATA_W-1:0]  w_strb_mask;
  logic [DATA_W-1:0]  w_merged;
  logic [ADDR_W-1:0]  w_ra [NUM_RD];
  logic [NUM_RD-1:0]  w_zero;
  logic [NUM_RD-1:0]  w_hit;

  // Gating with reset keeps a write that coincides with reset from being
  // forwarded on the bypass path, so reads are 0 while reset is high.
  assign w_wr_accept = rf.rf_we && !reset &&
                       !((ZERO_REG != 0) && (rf.rf_waddr == '0));

  always_comb begin
    w_strb_mask = '0;
    for (int k = 0; k < c_NBYTES; k++) begin
      w_strb_mask[k*8 +: 8] = {8{rf.rf_wstrb[k]}};
    end
  end

  // Word as it will look after this cycle's write; shared by storage and bypass.
  assign w_merged = (r_mem[rf.rf_waddr] & ~w_strb_mask) |
                    (rf.rf_wdata & w_strb_mask);

  // Read ports: zero register wins, then same-cycle bypass, then storage.
  always_comb begin
    rf.rf_rdata = '0;
    rf.rf_rbusy = '0;
    w_ra        = '{default: '0};
    w_zero      = '0;
    w_hit       = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_ra[i]   = rf.rf_raddr[i*ADDR_W +: ADDR_W];
      w_zero[i] = (ZERO_REG != 0) && (w_ra[i] == '0);
      w_hit[i]  = (BYPASS != 0) && w_wr_accept && (rf.rf_waddr == w_ra[i]);
      if (w_zero[i]) begin
        rf.rf_rdata[i*DATA_W +: DATA_W] = '0;
      end else if (w_hit[i]) begin
        rf.rf_rdata[i*DATA_W +: DATA_W] = w_merged;
      end else begin
        rf.rf_rdata[i*DATA_W +: DATA_W] = r_mem[w_ra[i]];
      end
      // Forwarded data is final, so a bypassed read is never reported busy.
      rf.rf_rbusy[i] = !w_zero[i] && !w_hit[i] && r_busy[w_ra[i]];
    end
  end

  // Scoreboard: flush beats alloc beats writeback clear. Alloc is applied
  // after the clear so a same-address alloc+write leaves the bit set.
  always_comb begin
    w_busy_nxt = r_busy;
    if (rf.flush) begin
      w_busy_nxt = '0;
    end else begin
      if (w_wr_accept) begin
        w_busy_nxt[rf.rf_waddr] = 1'b0;
      end
      if (rf.alloc_valid) begin
        w_busy_nxt[rf.alloc_addr] = 1'b1;
      end
    end
    if (ZERO_REG != 0) begin
      w_busy_nxt[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem <= '{default: '0};
    end else if (w_wr_accept) begin
      r_mem[rf.rf_waddr] <= w_merged;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy     <= '0;
      r_wr_ack   <= 1'b0;
      r_wr_count <= '0;
    end else begin
      r_busy   <= w_busy_nxt;
      r_wr_ack <= w_wr_accept;
      if (w_wr_accept) begin
        r_wr_count <= r_wr_count + CNT_W'(1);
      end
    end
  end

  assign rf.wr_ack   = r_wr_ack;
  assign rf.wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Self-checking bench for regfile_mp. Two instances share the
//                same stimulus: A (ZERO_REG=1, BYPASS=1, CNT_W=16) and
//                B (ZERO_REG=1, BYPASS=0, CNT_W=4). Directed vector table,
//                randomized traffic against a behavioural model, and hand
//                sequences for async reset and counter wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        we, av, fl;
  logic [4:0]  waddr, aa, ra0, ra1;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .CNT_W(16)) if_a ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .CNT_W(4))  if_b ();

  assign if_a.rf_raddr = {ra1, ra0};
  assign if_a.rf_we = we;
  assign if_a.rf_waddr = waddr;
  assign if_a.rf_wdata = wdata;
  assign if_a.rf_wstrb = wstrb;
  assign if_a.alloc_valid = av;
  assign if_a.alloc_addr = aa;
  assign if_a.flush = fl;
  assign if_b.rf_raddr = {ra1, ra0};
  assign if_b.rf_we = we;
  assign if_b.rf_waddr = waddr;
  assign if_b.rf_wdata = wdata;
  assign if_b.rf_wstrb = wstrb;
  assign if_b.alloc_valid = av;
  assign if_b.alloc_addr = aa;
  assign if_b.flush = fl;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1), .CNT_W(16))
    u_dut_a (.clk(clk), .reset(reset), .rf(if_a));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0), .CNT_W(4))
    u_dut_b (.clk(clk), .reset(reset), .rf(if_b));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  bit          m_ack;
  int unsigned m_cnt;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] s);
    logic [31:0] r = old_v;
    for (int k = 0; k < 4; k++) if (s[k]) r[k*8 +: 8] = new_v[k*8 +: 8];
    return r;
  endfunction

  function automatic bit acc();
    return (we === 1'b1) && (reset === 1'b0) && (waddr != 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] ra);
    if (ra == 5'd0) return 32'd0;
    if (byp && acc() && waddr == ra) return merge(m_mem[ra], wdata, wstrb);
    return m_mem[ra];
  endfunction

  function automatic bit exp_bz(input bit byp, input logic [4:0] ra);
    if (ra == 5'd0) return 1'b0;
    if (byp && acc() && waddr == ra) return 1'b0;
    return m_busy[ra];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 32'd0;
      m_busy[i] = 1'b0;
    end
    m_ack = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_update();
    bit a = acc();
    if (fl) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (a) m_busy[waddr] = 1'b0;
      if (av && aa != 5'd0) m_busy[aa] = 1'b1;
    end
    if (a) begin
      m_mem[waddr] = merge(m_mem[waddr], wdata, wstrb);
      m_cnt++;
    end
    m_ack = a;
  endtask

  task automatic check_model();
    chk("a_rd0", if_a.rf_rdata[31:0],  exp_rd(1'b1, ra0));
    chk("a_rd1", if_a.rf_rdata[63:32], exp_rd(1'b1, ra1));
    chk("b_rd0", if_b.rf_rdata[31:0],  exp_rd(1'b0, ra0));
    chk("b_rd1", if_b.rf_rdata[63:32], exp_rd(1'b0, ra1));
    chk("a_bz0", if_a.rf_rbusy[0], exp_bz(1'b1, ra0));
    chk("a_bz1", if_a.rf_rbusy[1], exp_bz(1'b1, ra1));
    chk("b_bz0", if_b.rf_rbusy[0], exp_bz(1'b0, ra0));
    chk("b_bz1", if_b.rf_rbusy[1], exp_bz(1'b0, ra1));
    chk("a_ack", if_a.wr_ack, m_ack);
    chk("b_ack", if_b.wr_ack, m_ack);
    chk("a_cnt", if_a.wr_count, m_cnt % 65536);
    chk("b_cnt", if_b.wr_count, m_cnt % 16);
  endtask

  task automatic cycle_model();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic we; logic [4:0] wa; logic [3:0] ws; logic [31:0] wd;
    logic av; logic [4:0] aa; logic fl; logic [4:0] r0, r1;
    logic [31:0] ar0, ar1, br0, br1;
    logic [1:0] abz, bbz; logic ack; int cnt;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] we_i, wa_i, ws_i, wd_i, av_i, aa_i, fl_i,
                              r0_i, r1_i, ar0_i, ar1_i, br0_i, br1_i, abz_i, bbz_i,
                              ack_i, cnt_i);
    vec_t v;
    v.we = we_i[0]; v.wa = wa_i[4:0]; v.ws = ws_i[3:0]; v.wd = wd_i;
    v.av = av_i[0]; v.aa = aa_i[4:0]; v.fl = fl_i[0];
    v.r0 = r0_i[4:0]; v.r1 = r1_i[4:0];
    v.ar0 = ar0_i; v.ar1 = ar1_i; v.br0 = br0_i; v.br1 = br1_i;
    v.abz = abz_i[1:0]; v.bbz = bbz_i[1:0]; v.ack = ack_i[0]; v.cnt = int'(cnt_i);
    return v;
  endfunction

  localparam int NV = 23;
  vec_t tv [NV];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          we wa ws  wdata        av aa fl r0 r1  a_rd0        a_rd1        b_rd0        b_rd1        abz bbz ack cnt
    tv[0]  = mk(1, 0, 'hF,'hDEADBEEF, 0, 0, 0, 0, 0, 0,           0,           0,           0,           0,  0,  0,  0);
    tv[1]  = mk(0, 0, 0,  0,          0, 0, 0, 0, 0, 0,           0,           0,           0,           0,  0,  0,  0);
    tv[2]  = mk(1, 5, 'hF,'h11223344, 0, 0, 0, 5, 5, 'h11223344, 'h11223344, 0,           0,           0,  0,  0,  0);
    tv[3]  = mk(1, 5, 'h5,'hAABBCCDD, 0, 0, 0, 5, 5, 'h11BB33DD, 'h11BB33DD, 'h11223344, 'h11223344, 0,  0,  1,  1);
    tv[4]  = mk(0, 0, 0,  0,          0, 0, 0, 5, 5, 'h11BB33DD, 'h11BB33DD, 'h11BB33DD, 'h11BB33DD, 0,  0,  1,  2);
    tv[5]  = mk(0, 0, 0,  0,          0, 0, 0, 7, 7, 0,           0,           0,           0,           0,  0,  0,  2);
    tv[6]  = mk(1, 7, 'hF,'h12345678, 0, 0, 0, 7, 7, 'h12345678, 'h12345678, 0,           0,           0,  0,  0,  2);
    tv[7]  = mk(0, 0, 0,  0,          1, 3, 0, 7, 3, 'h12345678, 0,           'h12345678, 0,           0,  0,  1,  3);
    tv[8]  = mk(0, 0, 0,  0,          0, 0, 0, 3, 3, 0,           0,           0,           0,           3,  3,  0,  3);
    tv[9]  = mk(1, 3, 'h1,'h000000AA, 0, 0, 0, 3, 3, 'hAA,        'hAA,        0,           0,           0,  3,  0,  3);
    tv[10] = mk(0, 0, 0,  0,          0, 0, 0, 3, 3, 'hAA,        'hAA,        'hAA,        'hAA,        0,  0,  1,  4);
    tv[11] = mk(1, 3, 'h1,'h000000BB, 1, 3, 0, 3, 3, 'hBB,        'hBB,        'hAA,        'hAA,        0,  0,  0,  4);
    tv[12] = mk(0, 0, 0,  0,          0, 0, 0, 3, 3, 'hBB,        'hBB,        'hBB,        'hBB,        3,  3,  1,  5);
    tv[13] = mk(0, 0, 0,  0,          1, 1, 0, 1, 2, 0,           0,           0,           0,           0,  0,  0,  5);
    tv[14] = mk(0, 0, 0,  0,          1, 2, 0, 1, 2, 0,           0,           0,           0,           1,  1,  0,  5);
    tv[15] = mk(0, 0, 0,  0,          1, 4, 0, 1, 2, 0,           0,           0,           0,           3,  3,  0,  5);
    tv[16] = mk(0, 0, 0,  0,          1, 6, 1, 4, 6, 0,           0,           0,           0,           1,  1,  0,  5);
    tv[17] = mk(0, 0, 0,  0,          0, 0, 0, 4, 6, 0,           0,           0,           0,           0,  0,  0,  5);
    tv[18] = mk(0, 0, 0,  0,          0, 0, 0, 3, 1, 'hBB,        0,           'hBB,        0,           0,  0,  0,  5);
    tv[19] = mk(0, 0, 0,  0,          1, 0, 0, 0, 0, 0,           0,           0,           0,           0,  0,  0,  5);
    tv[20] = mk(0, 0, 0,  0,          0, 0, 0, 0, 0, 0,           0,           0,           0,           0,  0,  0,  5);
    tv[21] = mk(1, 9, 0,  'hFFFFFFFF, 0, 0, 0, 9, 9, 0,           0,           0,           0,           0,  0,  0,  5);
    tv[22] = mk(0, 0, 0,  0,          0, 0, 0, 9, 9, 0,           0,           0,           0,           0,  0,  1,  6);

    we = 0; waddr = 0; wdata = 0; wstrb = 0; av = 0; aa = 0; fl = 0; ra0 = 0; ra1 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();                    // reset state
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < NV; i++) begin
      we = tv[i].we; waddr = tv[i].wa; wstrb = tv[i].ws; wdata = tv[i].wd;
      av = tv[i].av; aa = tv[i].aa; fl = tv[i].fl; ra0 = tv[i].r0; ra1 = tv[i].r1;
      @(negedge clk);
      chk($sformatf("row%0d a_rd0", i), if_a.rf_rdata[31:0],  tv[i].ar0);
      chk($sformatf("row%0d a_rd1", i), if_a.rf_rdata[63:32], tv[i].ar1);
      chk($sformatf("row%0d b_rd0", i), if_b.rf_rdata[31:0],  tv[i].br0);
      chk($sformatf("row%0d b_rd1", i), if_b.rf_rdata[63:32], tv[i].br1);
      chk($sformatf("row%0d a_bz", i),  if_a.rf_rbusy, tv[i].abz);
      chk($sformatf("row%0d b_bz", i),  if_b.rf_rbusy, tv[i].bbz);
      chk($sformatf("row%0d a_ack", i), if_a.wr_ack, tv[i].ack);
      chk($sformatf("row%0d b_ack", i), if_b.wr_ack, tv[i].ack);
      chk($sformatf("row%0d a_cnt", i), if_a.wr_count, tv[i].cnt);
      chk($sformatf("row%0d b_cnt", i), if_b.wr_count, tv[i].cnt % 16);
      @(posedge clk);
      model_update();
      #1;
    end

    // Randomized traffic on a small address window to force collisions
    for (int n = 0; n < 400; n++) begin
      we    = ($urandom_range(0, 99) < 60);
      waddr = 5'($urandom_range(0, 7));
      wdata = $urandom;
      wstrb = 4'($urandom_range(0, 15));
      av    = ($urandom_range(0, 99) < 30);
      aa    = 5'($urandom_range(0, 7));
      fl    = ($urandom_range(0, 99) < 5);
      ra0   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 7));
      ra1   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 7));
      cycle_model();
    end

    // Asynchronous reset in the middle of a write cycle
    we = 1; waddr = 5; wdata = 32'hCAFEF00D; wstrb = 4'hF; av = 1; aa = 6; fl = 0;
    ra0 = 5; ra1 = 6;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst a_rd0", if_a.rf_rdata[31:0], 32'd0);
    chk("arst a_rd1", if_a.rf_rdata[63:32], 32'd0);
    chk("arst b_rd0", if_b.rf_rdata[31:0], 32'd0);
    chk("arst a_bz", if_a.rf_rbusy, 2'b00);
    chk("arst a_ack", if_a.wr_ack, 1'b0);
    chk("arst a_cnt", if_a.wr_count, 16'd0);
    chk("arst b_cnt", if_b.wr_count, 4'd0);
    @(posedge clk);
    #1;
    reset = 1'b0; we = 0; av = 0;
    model_reset();
    for (int a = 0; a < 32; a++) begin
      ra0 = 5'(a); ra1 = 5'(31 - a);
      @(negedge clk);
      chk($sformatf("post_rst a_rd addr%0d", a), if_a.rf_rdata, 64'd0);
      chk($sformatf("post_rst b_rd addr%0d", a), if_b.rf_rdata, 64'd0);
      chk($sformatf("post_rst bz addr%0d", a), {if_a.rf_rbusy, if_b.rf_rbusy}, 4'd0);
    end
    chk("post_rst ack", {if_a.wr_ack, if_b.wr_ack}, 2'b00);
    chk("post_rst a_cnt", if_a.wr_count, 16'd0);
    @(posedge clk);
    #1;

    // Counter wrap: 17 back-to-back accepted writes, then a dropped write to r0
    for (int n = 0; n < 17; n++) begin
      we = 1; waddr = 5'(1 + n); wdata = $urandom; wstrb = 4'(n);
      av = 0; fl = 0; ra0 = waddr; ra1 = 0;
      @(negedge clk);
      chk($sformatf("wrap ack n%0d", n), if_b.wr_ack, (n > 0) ? 1'b1 : 1'b0);
      check_model();
      @(posedge clk);
      model_update();
      #1;
    end
    we = 1; waddr = 0; wdata = 32'hDEADBEEF; wstrb = 4'hF; ra0 = 0; ra1 = 0;
    @(negedge clk);
    chk("wrap b_cnt", if_b.wr_count, 4'd1);
    chk("wrap a_cnt", if_a.wr_count, 16'd17);
    chk("wrap ack last", if_a.wr_ack, 1'b1);
    @(posedge clk);
    model_update();
    #1;
    we = 0;
    @(negedge clk);
    chk("r0 drop ack", if_a.wr_ack, 1'b0);
    chk("r0 drop b_cnt", if_b.wr_count, 4'd1);
    chk("r0 drop a_cnt", if_a.wr_count, 16'd17);
    chk("r0 read", if_a.rf_rdata[31:0], 32'd0);
    check_model();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
